trace_capture: RTL and testbench
================================

# trace_capture

Hardware commit-trace receiver for the single-cycle RV32I core (`monociclo`). It samples the core's per-cycle debug outputs (PC, instruction, ALU result, next PC) into an on-chip FIFO, detects the end-of-program self-loop, and lets a host or bench drain entries through a valid/ready read port. It sits beside the core, fed only by its debug ports, and never back-pressures the core.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2.
- `CNT_W`, 16, width of `drop_count`.

- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-low reset.
- `trace_en`  in  1  capture enable, level-sensitive.
- `pc_in`  in  32  core `pc_out`.
- `inst_in`  in  32  core `inst_out`.
- `alu_in`  in  32  core `alu_result_out`.
- `next_pc_in`  in  32  core `next_pc_out`.
- `rd_valid`  out  1  FIFO non-empty.
- `rd_ready`  in  1  host accepts head entry.
- `rd_pc`, `rd_inst`, `rd_alu`  out  32 each  FIFO head entry.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `halted`  out  1  self-loop detected; sticky until IDLE.
- `drop_count`  out  CNT_W  samples lost to full FIFO; saturating.
- `cycle_count`  out  32  cycles spent in CAPTURE; wrapping.

## Operation
- FSM states IDLE, CAPTURE, HALTED.
- IDLE: no pushes. `trace_en`=1 → CAPTURE next edge; on that transition `drop_count`, `cycle_count`, `halted` clear. FIFO contents are kept.
- CAPTURE: every edge, push {pc_in, inst_in, alu_in}; `cycle_count`+1 (wraps 0xFFFFFFFF→0).
  - FIFO full and no pop this edge: sample dropped, `drop_count`+1, saturating at 2^CNT_W−1.
  - FIFO full with pop this edge: push and pop both happen, no drop, `level` unchanged.
  - `next_pc_in == pc_in`: this sample is still pushed (or dropped under the rules above). State → HALTED and `halted`←1 on the same edge.
  - `trace_en`=0: → IDLE, no push that edge. `trace_en` takes priority over halt detection.
- HALTED: no pushes, counters frozen. `trace_en`=0 → IDLE.
- Read port is active in every state. A pop occurs when `rd_valid && rd_ready`. `rd_ready` with an empty FIFO is ignored.
- Reset (async, any state, including mid-drain): state IDLE, FIFO emptied, all outputs 0 (`rd_*`, `level`, `halted`, `drop_count`, `cycle_count`, `rd_valid`).

## Timing
- Show-ahead FIFO. `rd_*` always reflect the head entry; `rd_valid = (level != 0)`.
- A sample taken at edge N is visible on `rd_*` (if FIFO was empty) and counted in `level` after edge N. Capture latency is 1 cycle.
- Pop at edge N: next entry appears after edge N. Sustained 1 entry/cycle throughput.
- Push and pop on the same edge are allowed at any occupancy. `level` updates by +1, −1 or 0 accordingly.
- `halted` rises after the edge that captures the self-loop sample.
- No combinational path from `rd_ready` to any output except through registered state.

## Structure
- Package `trace_pkg`:
  - `trace_state_t` enum {IDLE, CAPTURE, HALTED}.
  - `trace_entry_t` packed struct {pc, inst, alu}, each 32 bits.
- Sub-module `trace_fifo`:
  - Synchronous show-ahead FIFO of `trace_entry_t`, parameterised by `DEPTH`.
  - Pointers one bit wider than the address for full/empty detection.
  - Ports `push`, `pop`, `din`, `dout`, `full`, `empty`, `level`.
- Top level holds the FSM, halt compare, and counters.

## Test plan
- Reset mid-capture: 5 samples pushed, drop `reset` low asynchronously between edges → all outputs 0 immediately, `level`=0, state IDLE.
- Basic capture: `trace_en`=1, drive pc 0x0,0x4,0x8 with inst 0x00500093… and `rd_ready`=1 → `rd_pc` sequence 0x0,0x4,0x8 one per cycle, `cycle_count`=3, `drop_count`=0.
- Overflow: DEPTH=16, `rd_ready`=0, 20 capture cycles → `level`=16, `drop_count`=4; drain returns the first 16 PCs in order.
- Full with simultaneous pop: FIFO full, `rd_ready`=1 for 3 cycles while capturing → `level` stays 16, `drop_count` unchanged.
- Halt: pc 0x0,0x4,0x8, then pc=next_pc=0xAC → 4 entries, last `rd_pc`=0xAC, `halted`=1, `cycle_count` frozen at 4. Drop `trace_en` → IDLE; re-enable → `halted`=0 and counters 0.
- Saturation: CNT_W=4, `rd_ready`=0, DEPTH+20 cycles → `drop_count`=15 and holds.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types and defaults for the RV32I commit-trace receiver.
package trace_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HALTED  = 2'd2
  } trace_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] alu;
  } trace_entry_t;

  // A core parked on "j ." reports a next PC equal to its current PC.
  function automatic logic is_self_loop(input logic [XLEN-1:0] pc,
                                        input logic [XLEN-1:0] next_pc);
    return pc == next_pc;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO of trace entries; push while full is accepted only alongside a pop.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  trace_entry_t             din,
  output trace_entry_t             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  trace_entry_t  r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign level = r_wr_ptr - r_rd_ptr;

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Storage is not reset; the head is masked to zero whenever the FIFO is empty.
  assign dout = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/trace_capture.sv
// Commit-trace receiver: samples core debug ports into a FIFO and flags the end-of-program self-loop.
module trace_capture
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   trace_en,
  input  logic [XLEN-1:0]        pc_in,
  input  logic [XLEN-1:0]        inst_in,
  input  logic [XLEN-1:0]        alu_in,
  input  logic [XLEN-1:0]        next_pc_in,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [XLEN-1:0]        rd_pc,
  output logic [XLEN-1:0]        rd_inst,
  output logic [XLEN-1:0]        rd_alu,
  output logic [$clog2(DEPTH):0] level,
  output logic                   halted,
  output logic [CNT_W-1:0]       drop_count,
  output logic [XLEN-1:0]        cycle_count
);

  trace_state_t r_state;
  trace_state_t w_state_nxt;

  logic w_push;
  logic w_clr;
  logic w_count;
  logic w_halt_set;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_drop;

  trace_entry_t w_din;
  trace_entry_t w_dout;

  logic             r_halted;
  logic [CNT_W-1:0] r_drop;
  logic [XLEN-1:0]  r_cycle;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Disabling capture wins over halt detection in CAPTURE.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_clr       = 1'b0;
    w_count     = 1'b0;
    w_halt_set  = 1'b0;
    case (r_state)
      IDLE: begin
        if (trace_en) begin
          w_state_nxt = CAPTURE;
          w_clr       = 1'b1;
        end
      end
      CAPTURE: begin
        if (!trace_en) begin
          w_state_nxt = IDLE;
        end else begin
          w_push  = 1'b1;
          w_count = 1'b1;
          if (is_self_loop(pc_in, next_pc_in)) begin
            w_state_nxt = HALTED;
            w_halt_set  = 1'b1;
          end
        end
      end
      HALTED: begin
        if (!trace_en) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_din  = '{pc: pc_in, inst: inst_in, alu: alu_in};
  assign w_pop  = rd_valid && rd_ready;
  assign w_drop = w_push && w_full && !w_pop;

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .level (level)
  );

  // Status counters restart on every new capture session.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_halted <= 1'b0;
      r_drop   <= '0;
      r_cycle  <= '0;
    end else if (w_clr) begin
      r_halted <= 1'b0;
      r_drop   <= '0;
      r_cycle  <= '0;
    end else begin
      if (w_count)                  r_cycle  <= r_cycle + XLEN'(1);
      if (w_drop && (r_drop != '1)) r_drop   <= r_drop + CNT_W'(1);
      if (w_halt_set)               r_halted <= 1'b1;
    end
  end

  assign rd_valid    = !w_empty;
  assign rd_pc       = w_dout.pc;
  assign rd_inst     = w_dout.inst;
  assign rd_alu      = w_dout.alu;
  assign halted      = r_halted;
  assign drop_count  = r_drop;
  assign cycle_count = r_cycle;

endmodule

// File: tb/tb_trace_capture.sv
// Directed self-checking bench for trace_capture (DEPTH=16, CNT_W=4).
module tb_trace_capture;

  logic        clk;
  logic        reset;
  logic        trace_en;
  logic [31:0] pc_in;
  logic [31:0] inst_in;
  logic [31:0] alu_in;
  logic [31:0] next_pc_in;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_pc;
  logic [31:0] rd_inst;
  logic [31:0] rd_alu;
  logic [4:0]  level;
  logic        halted;
  logic [3:0]  drop_count;
  logic [31:0] cycle_count;

  int n_checks = 0;
  int n_fail   = 0;

  trace_capture #(
    .DEPTH (16),
    .CNT_W (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .trace_en    (trace_en),
    .pc_in       (pc_in),
    .inst_in     (inst_in),
    .alu_in      (alu_in),
    .next_pc_in  (next_pc_in),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_pc       (rd_pc),
    .rd_inst     (rd_inst),
    .rd_alu      (rd_alu),
    .level       (level),
    .halted      (halted),
    .drop_count  (drop_count),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [31:0] pc, input logic [31:0] npc);
    pc_in      = pc;
    next_pc_in = npc;
    inst_in    = 32'h0050_0093 ^ pc;
    alu_in     = pc + 32'h0000_1000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    trace_en = 1'b0;
    rd_ready = 1'b0;
    sample(32'h0, 32'h4);
    #12;
    check_eq("por_level",  32'(level), 32'd0);
    check_eq("por_valid",  32'(rd_valid), 32'd0);
    reset = 1'b1;

    // Reset in the middle of a capture session
    trace_en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      sample(32'(4 * i), 32'(4 * i + 4));
      tick();
    end
    check_eq("pre_rst_level", 32'(level), 32'd5);
    #2 reset = 1'b0;
    #1;
    check_eq("rst_level",  32'(level), 32'd0);
    check_eq("rst_valid",  32'(rd_valid), 32'd0);
    check_eq("rst_pc",     rd_pc, 32'd0);
    check_eq("rst_inst",   rd_inst, 32'd0);
    check_eq("rst_cycle",  cycle_count, 32'd0);
    check_eq("rst_drop",   32'(drop_count), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    #1 reset = 1'b1;
    tick();
    check_eq("rst_idle_nopush", 32'(level), 32'd0);
    trace_en = 1'b0;
    tick();

    // Basic capture with continuous drain
    rd_ready = 1'b1;
    trace_en = 1'b1;
    tick();
    sample(32'h0, 32'h4);
    tick();
    check_eq("basic_pc0",   rd_pc, 32'h0);
    check_eq("basic_inst0", rd_inst, 32'h0050_0093);
    check_eq("basic_lvl0",  32'(level), 32'd1);
    sample(32'h4, 32'h8);
    tick();
    check_eq("basic_pc1",   rd_pc, 32'h4);
    sample(32'h8, 32'hC);
    tick();
    check_eq("basic_pc2",   rd_pc, 32'h8);
    check_eq("basic_alu2",  rd_alu, 32'h1008);
    check_eq("basic_cycle", cycle_count, 32'd3);
    check_eq("basic_drop",  32'(drop_count), 32'd0);
    trace_en = 1'b0;
    tick();
    check_eq("basic_empty", 32'(rd_valid), 32'd0);
    check_eq("basic_cycle_exit", cycle_count, 32'd3);

    // Overflow without draining, then ordered drain
    rd_ready = 1'b0;
    trace_en = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      sample(32'h100 + 32'(4 * i), 32'h104 + 32'(4 * i));
      tick();
    end
    check_eq("ovf_level", 32'(level), 32'd16);
    check_eq("ovf_drop",  32'(drop_count), 32'd4);
    check_eq("ovf_cycle", cycle_count, 32'd20);
    trace_en = 1'b0;
    tick();
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_eq("ovf_drain_pc", rd_pc, 32'h100 + 32'(4 * i));
      tick();
    end
    check_eq("ovf_drained", 32'(level), 32'd0);
    tick();
    check_eq("ready_on_empty", 32'(level), 32'd0);
    check_eq("empty_pc_zero",  rd_pc, 32'd0);

    // Full FIFO with simultaneous push and pop
    rd_ready = 1'b0;
    trace_en = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      sample(32'h300 + 32'(4 * i), 32'h304 + 32'(4 * i));
      tick();
    end
    check_eq("fp_fill", 32'(level), 32'd16);
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample(32'h340 + 32'(4 * i), 32'h344 + 32'(4 * i));
      tick();
      check_eq("fp_level", 32'(level), 32'd16);
    end
    check_eq("fp_drop", 32'(drop_count), 32'd0);
    check_eq("fp_head", rd_pc, 32'h30C);
    trace_en = 1'b0;
    rd_ready = 1'b0;
    tick();
    rd_ready = 1'b1;
    repeat (15) tick();
    check_eq("fp_last_pc", rd_pc, 32'h348);
    check_eq("fp_last_lvl", 32'(level), 32'd1);
    tick();
    check_eq("fp_empty", 32'(level), 32'd0);

    // Self-loop halt
    rd_ready = 1'b0;
    trace_en = 1'b1;
    tick();
    sample(32'h0, 32'h4); tick();
    sample(32'h4, 32'h8); tick();
    sample(32'h8, 32'hC); tick();
    check_eq("halt_not_yet", 32'(halted), 32'd0);
    sample(32'hAC, 32'hAC); tick();
    check_eq("halt_flag",  32'(halted), 32'd1);
    check_eq("halt_level", 32'(level), 32'd4);
    check_eq("halt_cycle", cycle_count, 32'd4);
    sample(32'hB0, 32'hB4); tick();
    check_eq("halt_frozen_lvl", 32'(level), 32'd4);
    check_eq("halt_frozen_cyc", cycle_count, 32'd4);
    rd_ready = 1'b1;
    repeat (3) tick();
    check_eq("halt_last_pc",  rd_pc, 32'hAC);
    check_eq("halt_last_alu", rd_alu, 32'h10AC);
    tick();
    rd_ready = 1'b0;
    check_eq("halt_drained", 32'(level), 32'd0);
    trace_en = 1'b0;
    tick();
    check_eq("halt_sticky_idle", 32'(halted), 32'd1);
    trace_en = 1'b1;
    tick();
    check_eq("rearm_halted", 32'(halted), 32'd0);
    check_eq("rearm_cycle",  cycle_count, 32'd0);
    check_eq("rearm_drop",   32'(drop_count), 32'd0);
    sample(32'hC0, 32'hC0);
    trace_en = 1'b0;
    tick();
    check_eq("prio_halted", 32'(halted), 32'd0);
    check_eq("prio_nopush", 32'(level), 32'd0);

    // Drop counter saturation
    trace_en = 1'b1;
    tick();
    for (int i = 0; i < 36; i++) begin
      sample(32'h400 + 32'(4 * i), 32'h404 + 32'(4 * i));
      tick();
    end
    check_eq("sat_drop",  32'(drop_count), 32'd15);
    check_eq("sat_level", 32'(level), 32'd16);
    sample(32'h600, 32'h604);
    tick();
    check_eq("sat_hold",  32'(drop_count), 32'd15);
    check_eq("sat_cycle", cycle_count, 32'd37);
    check_eq("sat_head",  rd_pc, 32'h400);
    trace_en = 1'b0;
    tick();
    rd_ready = 1'b1;
    repeat (16) tick();
    check_eq("sat_drained", 32'(level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
